// File: rtl/qdr_cpu_engine.sv
// Purpose  : Wishbone register front-end that moves one cache line to/from a QDR memory port.
// Latency  : ack one cycle after each bus transaction; write burst BEATS+1 cycles, read bounded by TIMEOUT.
// Backpres.: no bus stall; starts while busy or with phy_rdy low are dropped, memory side never stalls.
module qdr_cpu_engine #(
   parameter int DATA_W  = 72,
   parameter int BEATS   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   input  logic              phy_rdy,
   input  logic              cal_fail,
   output logic [31:0]       qdr_addr,
   output logic              qdr_wr_en,
   output logic [DATA_W-1:0] qdr_wr_data,
   output logic              qdr_rd_en,
   input  logic [DATA_W-1:0] qdr_rd_data,
   input  logic              qdr_rd_dvld
);

   localparam int LINE_W = DATA_W * BEATS;
   localparam int NW     = (LINE_W + 31) / 32;
   localparam int CNT_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_REQ,
      S_RD_CAP,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic                rd_pend_q, rd_pend_d;
   logic                wr_pend_q, wr_pend_d;
   logic                auto_inc_q, auto_inc_d;
   logic                tflag_q, tflag_d;
   logic                op_tmo_q, op_tmo_d;
   logic                ack_q, ack_d;
   logic [31:0]         addr_q, addr_d;
   logic [LINE_W-1:0]   wline_q, wline_d;
   logic [LINE_W-1:0]   rline_q, rline_d;
   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [CNT_W-1:0]    cap_q, cap_d;
   logic [15:0]         tmo_q, tmo_d;

   // bus decode
   logic [6:0]  widx;
   logic [9:0]  wsh;
   logic        wb_txn, wb_wr;
   logic        ctl_wr, addr_wr, wl_wr;
   logic        start_rd, start_wr;
   logic        in_rd, cap_hit, rd_last, tmo_hit, wr_last;
   logic [15:0] tmo_inc;
   logic        busy;
   logic        unused_in;

   assign widx     = wb_adr_i[8:2];
   assign wsh      = {widx[4:0], 5'b0};
   assign wb_txn   = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wb_wr    = wb_txn & wb_we_i;
   assign ctl_wr   = wb_wr & (widx == 7'd1);
   assign addr_wr  = wb_wr & (widx == 7'd2);
   assign wl_wr    = wb_wr & (widx[6:5] == 2'b01) & (32'(widx[4:0]) < NW);

   // read has priority over write when both start bits are set
   assign start_rd = ctl_wr & wb_dat_i[0] & (state_q == S_IDLE) & phy_rdy;
   assign start_wr = ctl_wr & wb_dat_i[8] & ~wb_dat_i[0] & (state_q == S_IDLE) & phy_rdy;

   assign in_rd    = (state_q == S_RD_REQ) | (state_q == S_RD_CAP);
   assign cap_hit  = in_rd & qdr_rd_dvld;
   assign rd_last  = cap_hit & (cap_q == CNT_W'(BEATS - 1));
   assign tmo_inc  = tmo_q + 16'd1;
   // a beat completing the line in the timeout cycle wins over the timeout
   assign tmo_hit  = in_rd & (tmo_inc == 16'(TIMEOUT)) & ~rd_last;
   assign wr_last  = (state_q == S_WR) & (beat_q == CNT_W'(BEATS - 1));

   assign wb_ack_o  = ack_q;
   assign wb_err_o  = 1'b0;
   assign qdr_addr  = addr_q;
   assign unused_in = ^{wb_sel_i, wb_adr_i[31:9], wb_adr_i[1:0]};

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q    <= S_IDLE;
         rd_pend_q  <= 1'b0;
         wr_pend_q  <= 1'b0;
         auto_inc_q <= 1'b0;
         tflag_q    <= 1'b0;
         op_tmo_q   <= 1'b0;
         ack_q      <= 1'b0;
         addr_q     <= '0;
         wline_q    <= '0;
         rline_q    <= '0;
         beat_q     <= '0;
         cap_q      <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         rd_pend_q  <= rd_pend_d;
         wr_pend_q  <= wr_pend_d;
         auto_inc_q <= auto_inc_d;
         tflag_q    <= tflag_d;
         op_tmo_q   <= op_tmo_d;
         ack_q      <= ack_d;
         addr_q     <= addr_d;
         wline_q    <= wline_d;
         rline_q    <= rline_d;
         beat_q     <= beat_d;
         cap_q      <= cap_d;
         tmo_q      <= tmo_d;
      end
   end

   // next-state: write burst runs a fixed BEATS cycles, read waits for beats or timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_rd) begin
               state_d = S_RD_REQ;
            end else if (start_wr) begin
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (wr_last) begin
               state_d = S_DONE;
            end
         end
         S_RD_REQ: begin
            if (rd_last || tmo_hit) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RD_CAP;
            end
         end
         S_RD_CAP: begin
            if (rd_last || tmo_hit) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: single-cycle enables on the first beat / request cycle
   always_comb begin
      busy      = (state_q != S_IDLE);
      qdr_wr_en = (state_q == S_WR) && (beat_q == '0);
      qdr_rd_en = (state_q == S_RD_REQ);
   end

   // write data mux; beat counter rests at 0 so idle presents beat 0
   always_comb begin
      qdr_wr_data = wline_q[DATA_W-1:0];
      for (int b = 0; b < BEATS; b++) begin
         if (32'(beat_q) == b) begin
            qdr_wr_data = wline_q[b*DATA_W +: DATA_W];
         end
      end
   end

   // control/status register, counter and address updates
   always_comb begin
      ack_d      = wb_txn;
      auto_inc_d = ctl_wr ? wb_dat_i[24] : auto_inc_q;

      rd_pend_d = rd_pend_q;
      wr_pend_d = wr_pend_q;
      if (start_rd) rd_pend_d = 1'b1;
      if (start_wr) wr_pend_d = 1'b1;
      if (state_q == S_DONE) begin
         rd_pend_d = 1'b0;
         wr_pend_d = 1'b0;
      end

      tflag_d = tflag_q;
      if (ctl_wr && wb_dat_i[16]) tflag_d = 1'b0;
      if (tmo_hit)                tflag_d = 1'b1;

      // per-operation timeout memory so a stale sticky flag does not block auto_inc
      op_tmo_d = op_tmo_q;
      if (start_rd || start_wr) op_tmo_d = 1'b0;
      if (tmo_hit)              op_tmo_d = 1'b1;

      addr_d = addr_q;
      if ((state_q == S_DONE) && auto_inc_q && !op_tmo_q) addr_d = addr_q + 32'd1;
      if (addr_wr)                                      addr_d = wb_dat_i;

      beat_d = ((state_q == S_WR) && !wr_last) ? beat_q + 1'b1 : '0;

      cap_d = cap_q;
      if (start_rd)     cap_d = '0;
      else if (cap_hit) cap_d = cap_q + 1'b1;

      tmo_d = tmo_q;
      if (start_rd)   tmo_d = '0;
      else if (in_rd) tmo_d = tmo_inc;
   end

   // line buffers: bus writes into the write line, captured beats into the read line
   always_comb begin
      logic [LINE_W-1:0] wmask;
      logic [LINE_W-1:0] wval;
      wmask   = LINE_W'(32'hFFFF_FFFF) << wsh;
      wval    = LINE_W'(wb_dat_i) << wsh;
      wline_d = wline_q;
      if (wl_wr) begin
         wline_d = (wline_q & ~wmask) | (wval & wmask);
      end
      rline_d = rline_q;
      for (int b = 0; b < BEATS; b++) begin
         if (cap_hit && (32'(cap_q) == b)) begin
            rline_d[b*DATA_W +: DATA_W] = qdr_rd_data;
         end
      end
   end

   // combinational register read mux; unmapped words return 0
   always_comb begin
      wb_dat_o = '0;
      if (widx == 7'd0) begin
         wb_dat_o = {14'b0, tflag_q, busy, 7'b0, cal_fail, 7'b0, phy_rdy};
      end else if (widx == 7'd1) begin
         wb_dat_o = {7'b0, auto_inc_q, 15'b0, wr_pend_q, 7'b0, rd_pend_q};
      end else if (widx == 7'd2) begin
         wb_dat_o = addr_q;
      end else if ((widx[6:5] == 2'b01) && (32'(widx[4:0]) < NW)) begin
         wb_dat_o = 32'(wline_q >> wsh);
      end else if ((widx[6:5] == 2'b10) && (32'(widx[4:0]) < NW)) begin
         wb_dat_o = 32'(rline_q >> wsh);
      end
   end

endmodule

// File: tb/tb_qdr_cpu_engine.sv
// Directed bench for qdr_cpu_engine with DATA_W=72, BEATS=2, TIMEOUT=8.
// Bus inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// Register reads use the combinational read mux without issuing a bus cycle.
module tb_qdr_cpu_engine;

   logic        clk;
   logic        rst_n;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic        wb_ack_o, wb_err_o;
   logic        phy_rdy, cal_fail;
   logic [31:0] qdr_addr;
   logic        qdr_wr_en, qdr_rd_en;
   logic [71:0] qdr_wr_data, qdr_rd_data;
   logic        qdr_rd_dvld;

   int tests = 0;
   int fails = 0;

   qdr_cpu_engine #(.DATA_W(72), .BEATS(2), .TIMEOUT(8)) dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rst_n),
      .wb_cyc_i    (wb_cyc_i),
      .wb_stb_i    (wb_stb_i),
      .wb_we_i     (wb_we_i),
      .wb_sel_i    (wb_sel_i),
      .wb_adr_i    (wb_adr_i),
      .wb_dat_i    (wb_dat_i),
      .wb_dat_o    (wb_dat_o),
      .wb_ack_o    (wb_ack_o),
      .wb_err_o    (wb_err_o),
      .phy_rdy     (phy_rdy),
      .cal_fail    (cal_fail),
      .qdr_addr    (qdr_addr),
      .qdr_wr_en   (qdr_wr_en),
      .qdr_wr_data (qdr_wr_data),
      .qdr_rd_en   (qdr_rd_en),
      .qdr_rd_data (qdr_rd_data),
      .qdr_rd_dvld (qdr_rd_dvld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
      logic [31:0] d;
      wb_adr_i = 32'(idx) << 2;
      #1;
      d = wb_dat_o;
      check(tag, 72'(d), 72'(exp));
   endtask

   // one write transaction; returns 1 unit after the accepting edge (ack is high then)
   task automatic wb_start(input int idx, input logic [31:0] dat);
      wb_adr_i = 32'(idx) << 2;
      wb_dat_i = dat;
      wb_we_i  = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(posedge clk); #1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic wb_write(input int idx, input logic [31:0] dat);
      wb_start(idx, dat);
      @(posedge clk); #1;
   endtask

   initial begin
      int seen;
      logic [31:0] d;
      rst_n = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_sel_i = 4'hF; wb_adr_i = '0; wb_dat_i = '0;
      phy_rdy = 1'b1; cal_fail = 1'b0; qdr_rd_data = '0; qdr_rd_dvld = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      check("rst_wr_en", qdr_wr_en, 0);
      check("rst_rd_en", qdr_rd_en, 0);
      check("rst_ack", wb_ack_o, 0);
      check("rst_err", wb_err_o, 0);
      check("rst_qdr_addr", qdr_addr, 0);
      chk_reg("rst_status", 0, 32'h1);
      chk_reg("rst_ctrl", 1, 32'h0);

      // held cyc/stb: ack alternates
      wb_adr_i = 32'h0; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check($sformatf("ack_alt%0d", i), wb_ack_o, (i % 2 == 0) ? 1 : 0);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(posedge clk); #1;
      chk_reg("unmapped40", 40, 32'h0);
      chk_reg("unmapped3", 3, 32'h0);

      // write burst
      wb_write(2, 32'h10);
      wb_write(32, 32'h1111_1111);
      wb_write(33, 32'h2222_2222);
      wb_write(34, 32'h3333_3333);
      wb_write(35, 32'h4444_4444);
      wb_write(36, 32'hFFFF_5555);
      chk_reg("wl36_trunc", 36, 32'h0000_5555);
      chk_reg("wl34", 34, 32'h3333_3333);
      chk_reg("unmapped37", 37, 32'h0);
      chk_reg("addr_reg", 2, 32'h10);
      wb_start(1, 32'h100);
      check("wr_en_b0", qdr_wr_en, 1);
      check("wr_addr", qdr_addr, 32'h10);
      check("wr_beat0", qdr_wr_data, 72'h33_2222_2222_1111_1111);
      check("wr_ack", wb_ack_o, 1);
      check("wr_rd_en", qdr_rd_en, 0);
      chk_reg("wr_ctrl_pend", 1, 32'h100);
      chk_reg("wr_status_busy", 0, 32'h1_0001);
      @(posedge clk); #1;
      check("wr_en_b1", qdr_wr_en, 0);
      check("wr_beat1", qdr_wr_data, 72'h5555_4444_4444_3333_33);
      check("wr_ack_low", wb_ack_o, 0);
      @(posedge clk); #1;
      check("wr_en_done", qdr_wr_en, 0);
      @(posedge clk); #1;
      chk_reg("wr_ctrl_after", 1, 32'h0);
      chk_reg("wr_status_after", 0, 32'h1);
      chk_reg("wr_addr_after", 2, 32'h10);
      check("idle_beat0", qdr_wr_data, 72'h33_2222_2222_1111_1111);

      // read with auto_inc, beats 3 cycles apart
      wb_start(1, 32'h0100_0001);
      check("rd_en_pulse", qdr_rd_en, 1);
      check("rd_addr", qdr_addr, 32'h10);
      qdr_rd_dvld = 1'b1; qdr_rd_data = 72'hAA_AAAA_AAAA_AAAA_AAAA;
      @(posedge clk); #1;
      qdr_rd_dvld = 1'b0; qdr_rd_data = '0;
      check("rd_en_low", qdr_rd_en, 0);
      chk_reg("rd_ctrl_pend", 1, 32'h0100_0001);
      @(posedge clk); #1;
      @(posedge clk); #1;
      qdr_rd_dvld = 1'b1; qdr_rd_data = 72'hBB_BBBB_BBBB_BBBB_BBBB;
      @(posedge clk); #1;
      qdr_rd_dvld = 1'b0; qdr_rd_data = '0;
      @(posedge clk); #1;
      check("rd_qdr_addr_inc", qdr_addr, 32'h11);
      chk_reg("rd_addr_inc", 2, 32'h11);
      chk_reg("rd_ctrl_after", 1, 32'h0100_0000);
      chk_reg("rd_status_after", 0, 32'h1);
      chk_reg("rl64", 64, 32'hAAAA_AAAA);
      chk_reg("rl65", 65, 32'hAAAA_AAAA);
      chk_reg("rl66", 66, 32'hBBBB_BBAA);
      chk_reg("rl67", 67, 32'hBBBB_BBBB);
      chk_reg("rl68", 68, 32'h0000_BBBB);

      // dvld while idle is ignored
      qdr_rd_dvld = 1'b1; qdr_rd_data = 72'h12_3456_789A_BCDE_F012;
      @(posedge clk); #1;
      qdr_rd_dvld = 1'b0; qdr_rd_data = '0;
      chk_reg("idle_dvld_ignored", 64, 32'hAAAA_AAAA);

      // both start bits: read only; start while busy ignored
      wb_start(1, 32'h101);
      chk_reg("both_ctrl", 1, 32'h1);
      check("both_rd_en", qdr_rd_en, 1);
      check("both_wr_en", qdr_wr_en, 0);
      wb_write(1, 32'h100);
      chk_reg("busy_start_ignored", 1, 32'h1);
      chk_reg("busy_status", 0, 32'h1_0001);
      qdr_rd_dvld = 1'b1; qdr_rd_data = 72'hCC_CCCC_CCCC_CCCC_CCCC;
      @(posedge clk); #1;
      qdr_rd_data = 72'hDD_DDDD_DDDD_DDDD_DDDD;
      @(posedge clk); #1;
      qdr_rd_dvld = 1'b0; qdr_rd_data = '0;
      @(posedge clk); #1;
      chk_reg("busy_rd_status", 0, 32'h1);
      chk_reg("busy_rd_ctrl", 1, 32'h0);
      chk_reg("busy_rd_addr_kept", 2, 32'h11);
      chk_reg("busy_rl64", 64, 32'hCCCC_CCCC);
      chk_reg("busy_rl67", 67, 32'hDDDD_DDDD);

      // start with phy_rdy low is dropped
      phy_rdy = 1'b0;
      wb_start(1, 32'h100);
      check("nophy_wr_en", qdr_wr_en, 0);
      chk_reg("nophy_status", 0, 32'h0);
      @(posedge clk); #1;
      phy_rdy = 1'b1;

      // read timeout: no dvld, flag after TIMEOUT cycles, no address increment
      wb_start(1, 32'h0100_0001);
      seen = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         wb_adr_i = 32'h0;
         #1;
         d = wb_dat_o;
         if (d[17] && seen == 0) seen = i;
      end
      check("tmo_latency", 72'(seen), 72'd8);
      chk_reg("tmo_status", 0, 32'h2_0001);
      chk_reg("tmo_addr_kept", 2, 32'h11);
      chk_reg("tmo_ctrl", 1, 32'h0100_0000);
      wb_write(1, 32'h1_0000);
      chk_reg("tmo_cleared", 0, 32'h1);
      chk_reg("tmo_autoinc_cleared", 1, 32'h0);

      // reset during write beat 1
      cal_fail = 1'b1;
      wb_write(2, 32'h20);
      wb_start(1, 32'h100);
      check("rstwr_en_b0", qdr_wr_en, 1);
      check("rstwr_addr", qdr_addr, 32'h20);
      @(posedge clk); #1;
      check("rstwr_beat1", qdr_wr_data, 72'h5555_4444_4444_3333_33);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rstwr_wr_en", qdr_wr_en, 0);
      check("rstwr_rd_en", qdr_rd_en, 0);
      check("rstwr_qdr_addr", qdr_addr, 32'h0);
      chk_reg("rstwr_status", 0, 32'h101);
      chk_reg("rstwr_ctrl", 1, 32'h0);
      chk_reg("rstwr_wline", 32, 32'h0);
      @(posedge clk); #1;
      check("rstwr_wr_en_later", qdr_wr_en, 0);
      chk_reg("rstwr_status_later", 0, 32'h101);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
